// File: rtl/spi_flash_seq_pkg.sv
// Shared types and tie-off constants for the SPI flash read sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_flash_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_RX,
        ST_WAIT
    } state_t;

    // Flash READ opcode, always the first byte on the wire
    localparam logic [7:0]  RD_OPCODE_DEF = 8'h03;
    // Header segment is opcode + 3 address bytes, length field is bytes-1
    localparam logic [8:0]  HDR_LEN       = 9'd3;

    // Static SPI host core configuration tied off at integration
    localparam logic [15:0] CLKDIV        = 16'd1;
    localparam logic [3:0]  CSNIDLE       = 4'd1;
    localparam logic [3:0]  CSNLEAD       = 4'd1;
    localparam logic [3:0]  CSNTRAIL      = 4'd1;
    localparam logic        CPOL          = 1'b0;
    localparam logic        CPHA          = 1'b0;
    localparam logic        FULL_CYC      = 1'b0;
    localparam logic        CSID          = 1'b0;
    localparam logic [1:0]  SPEED         = 2'd0;   // standard single-lane mode

    // Keep byte lanes below 'tail' valid; tail==0 means the whole word is valid
    function automatic logic [31:0] tail_mask(input logic [1:0] tail);
        logic [31:0] m;
        case (tail)
            2'd1:    m = 32'h0000_00FF;
            2'd2:    m = 32'h0000_FFFF;
            2'd3:    m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/spi_flash_rd_seq_rx_stage.sv
// One-entry registered valid/ready output stage with last flag and tail-byte masking.
// Latency: 1 cycle from accepted input to output valid.
// Backpressure: full-throughput; input ready while empty or while the held word drains.
module spi_rx_out_stage
    import spi_flash_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    input  logic        in_last_i,
    input  logic [1:0]  tail_i,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    output logic        out_last_o,
    input  logic        out_ready_i
);

    assign in_ready_o = ~out_valid_o | out_ready_i;

    // Hold one word; flush beats any load or drain in the same cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_data_o  <= 32'd0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end else if (flush_i) begin
            out_data_o  <= 32'd0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            out_data_o  <= in_last_i ? (in_data_i & tail_mask(tail_i)) : in_data_i;
            out_valid_o <= 1'b1;
            out_last_o  <= in_last_i;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_flash_rd_seq.sv
// Sequences a single-lane SPI flash READ (header segment, then read segment) through the host core.
// Latency: request to header valid 1 cycle; last word handoff to done_o at least 1 cycle.
// Backpressure: req_ready_o only in IDLE; RX words stall via rx_ready_o while the output stage is full.
module spi_flash_rd_seq
    import spi_flash_seq_pkg::*;
#(
    parameter logic [7:0] RD_OPCODE = RD_OPCODE_DEF,
    parameter int         MAX_BYTES = 512
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [23:0] req_addr_i,
    input  logic [9:0]  req_bytes_i,
    input  logic        abort_i,
    output logic [31:0] rd_data_o,
    output logic        rd_valid_o,
    output logic        rd_last_o,
    input  logic        rd_ready_i,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        cmd_wr_en_o,
    output logic        cmd_rd_en_o,
    output logic [8:0]  cmd_len_o,
    output logic        cmd_csaat_o,
    output logic        en_o,
    output logic        sw_rst_o,
    output logic [31:0] tx_data_o,
    output logic [3:0]  tx_be_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [31:0] rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    input  logic        active_i
);

    localparam logic [9:0] MAX_B = 10'(MAX_BYTES);

    state_t      state;
    logic [8:0]  len_q;
    logic [7:0]  words_q;
    logic [1:0]  tail_q;
    logic        tx_done_q;
    logic        cmd_done_q;

    logic        req_ok;
    logic [9:0]  bytes_p3;
    logic        tx_hs;
    logic        cmd_hs;
    logic        abort_hit;
    logic        in_rx;
    logic        st_in_valid;
    logic        st_in_ready;
    logic        st_in_last;
    logic        rd_hs_last;

    assign req_ok      = (req_bytes_i != 10'd0) && (req_bytes_i <= MAX_B);
    assign bytes_p3    = req_bytes_i + 10'd3;
    assign tx_hs       = tx_valid_o & tx_ready_i;
    assign cmd_hs      = cmd_valid_o & cmd_ready_i;
    assign abort_hit   = abort_i & (state != ST_IDLE);
    assign in_rx       = (state == ST_RX);
    assign st_in_valid = rx_valid_i & in_rx;
    assign st_in_last  = (words_q == 8'd1);
    assign rx_ready_o  = in_rx & st_in_ready;
    assign rd_hs_last  = rd_valid_o & rd_ready_i & rd_last_o;
    assign req_ready_o = (state == ST_IDLE);
    assign busy_o      = (state != ST_IDLE);
    assign tx_be_o     = 4'hF;

    spi_rx_out_stage u_rx_stage (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (abort_hit),
        .in_valid_i  (st_in_valid),
        .in_ready_o  (st_in_ready),
        .in_data_i   (rx_data_i),
        .in_last_i   (st_in_last),
        .tail_i      (tail_q),
        .out_data_o  (rd_data_o),
        .out_valid_o (rd_valid_o),
        .out_last_o  (rd_last_o),
        .out_ready_i (rd_ready_i)
    );

    // Core enable comes up one cycle after reset release and stays on
    always_ff @(posedge clk_i) begin
        if (!rst_ni) en_o <= 1'b0;
        else         en_o <= 1'b1;
    end

    // Transaction FSM: header push, read command, RX drain, wait for core idle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            len_q       <= 9'd0;
            words_q     <= 8'd0;
            tail_q      <= 2'd0;
            tx_done_q   <= 1'b0;
            cmd_done_q  <= 1'b0;
            tx_data_o   <= 32'd0;
            tx_valid_o  <= 1'b0;
            cmd_valid_o <= 1'b0;
            cmd_wr_en_o <= 1'b0;
            cmd_rd_en_o <= 1'b0;
            cmd_len_o   <= 9'd0;
            cmd_csaat_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            sw_rst_o    <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            sw_rst_o <= 1'b0;
            if (abort_hit) begin
                // Same-cycle handshakes are dropped; the core is soft-reset anyway
                state       <= ST_IDLE;
                sw_rst_o    <= 1'b1;
                err_o       <= 1'b1;
                tx_valid_o  <= 1'b0;
                cmd_valid_o <= 1'b0;
                tx_done_q   <= 1'b0;
                cmd_done_q  <= 1'b0;
                len_q       <= 9'd0;
                words_q     <= 8'd0;
                tail_q      <= 2'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req_valid_i) begin
                            if (!req_ok) begin
                                err_o <= 1'b1;
                            end else begin
                                len_q       <= 9'(req_bytes_i - 10'd1);
                                words_q     <= bytes_p3[9:2];
                                tail_q      <= req_bytes_i[1:0];
                                tx_data_o   <= {req_addr_i[7:0], req_addr_i[15:8],
                                                req_addr_i[23:16], RD_OPCODE};
                                tx_valid_o  <= 1'b1;
                                cmd_valid_o <= 1'b1;
                                cmd_wr_en_o <= 1'b1;
                                cmd_rd_en_o <= 1'b0;
                                cmd_len_o   <= HDR_LEN;
                                cmd_csaat_o <= 1'b1;
                                tx_done_q   <= 1'b0;
                                cmd_done_q  <= 1'b0;
                                state       <= ST_HDR;
                            end
                        end
                    end
                    ST_HDR: begin
                        if (tx_hs) begin
                            tx_valid_o <= 1'b0;
                            tx_done_q  <= 1'b1;
                        end
                        if (cmd_hs) begin
                            cmd_valid_o <= 1'b0;
                            cmd_done_q  <= 1'b1;
                        end
                        // Both header pieces taken: present the read segment next cycle
                        if ((tx_done_q | tx_hs) && (cmd_done_q | cmd_hs)) begin
                            cmd_valid_o <= 1'b1;
                            cmd_wr_en_o <= 1'b0;
                            cmd_rd_en_o <= 1'b1;
                            cmd_len_o   <= len_q;
                            cmd_csaat_o <= 1'b0;
                            state       <= ST_RD;
                        end
                    end
                    ST_RD: begin
                        if (cmd_hs) begin
                            cmd_valid_o <= 1'b0;
                            state       <= ST_RX;
                        end
                    end
                    ST_RX: begin
                        if (st_in_valid && st_in_ready) words_q <= words_q - 8'd1;
                        if (rd_hs_last) begin
                            if (!active_i) begin
                                done_o <= 1'b1;
                                state  <= ST_IDLE;
                            end else begin
                                state  <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (!active_i) begin
                            done_o <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Directed bench for the SPI flash read sequencer with a hand-driven core model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_spi_flash_rd_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [23:0] req_addr_i;
    logic [9:0]  req_bytes_i;
    logic        abort_i;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        rd_last_o;
    logic        rd_ready_i;
    logic        done_o;
    logic        err_o;
    logic        busy_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic        cmd_wr_en_o;
    logic        cmd_rd_en_o;
    logic [8:0]  cmd_len_o;
    logic        cmd_csaat_o;
    logic        en_o;
    logic        sw_rst_o;
    logic [31:0] tx_data_o;
    logic [3:0]  tx_be_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [31:0] rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        active_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rx_words[$];
    logic [31:0] exp_words[$];

    always #5 clk_i = ~clk_i;

    spi_flash_rd_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_bytes_i (req_bytes_i),
        .abort_i     (abort_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .rd_last_o   (rd_last_o),
        .rd_ready_i  (rd_ready_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_ready_i (cmd_ready_i),
        .cmd_wr_en_o (cmd_wr_en_o),
        .cmd_rd_en_o (cmd_rd_en_o),
        .cmd_len_o   (cmd_len_o),
        .cmd_csaat_o (cmd_csaat_o),
        .en_o        (en_o),
        .sw_rst_o    (sw_rst_o),
        .tx_data_o   (tx_data_o),
        .tx_be_o     (tx_be_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .active_i    (active_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns at the next falling edge
    task automatic send_req(input logic [23:0] a, input logic [9:0] b);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_bytes_i = b;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    // Header phase with immediate TX accept and cmd_ready held low for cmd_delay cycles;
    // returns in RD with cmd_ready_i high so the read command is taken at the next edge
    task automatic hdr_phase(input logic [23:0] a, input logic [8:0] exp_len, input int cmd_delay);
        logic [31:0] exp_tx;
        exp_tx = {a[7:0], a[15:8], a[23:16], 8'h03};
        #1;
        check("hdr_tx_valid", 32'(tx_valid_o), 32'd1);
        check("hdr_tx_data", tx_data_o, exp_tx);
        check("hdr_cmd", 32'({cmd_valid_o, cmd_wr_en_o, cmd_rd_en_o, cmd_csaat_o, cmd_len_o}), 32'h0000_1A03);
        check("hdr_tx_be", 32'(tx_be_o), 32'hF);
        check("hdr_busy_rdy", 32'({busy_o, req_ready_o}), 32'b10);
        rx_valid_i = 1'b1;
        check("hdr_rx_ready", 32'(rx_ready_o), 32'd0);
        rx_valid_i = 1'b0;
        tx_ready_i  = 1'b1;
        cmd_ready_i = (cmd_delay == 0);
        for (int i = 1; i < cmd_delay; i++) begin
            @(negedge clk_i);
            tx_ready_i = 1'b0;
            #1;
            check("hdr_tx_drop", 32'(tx_valid_o), 32'd0);
            check("hdr_cmd_hold", 32'({cmd_valid_o, cmd_wr_en_o, cmd_rd_en_o, cmd_csaat_o, cmd_len_o}), 32'h0000_1A03);
        end
        if (cmd_delay > 0) begin
            @(negedge clk_i);
            tx_ready_i = 1'b0;
            #1;
            check("hdr_cmd_hold", 32'({cmd_valid_o, cmd_wr_en_o, cmd_rd_en_o, cmd_csaat_o, cmd_len_o}), 32'h0000_1A03);
            cmd_ready_i = 1'b1;
        end
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        #1;
        check("rd_cmd", 32'({cmd_valid_o, cmd_wr_en_o, cmd_rd_en_o, cmd_csaat_o, cmd_len_o}),
              32'h0000_1400 | {23'd0, exp_len});
        check("rd_tx_idle", 32'(tx_valid_o), 32'd0);
    endtask

    // Feed rx_words, collect and compare output words, then wait for done_o
    task automatic stream(input int n, input int stall_at, input int stall_len, input int active_hold);
        int  ri  = 0;
        int  oi  = 0;
        int  cyc = 0;
        bit  seen = 0;
        @(negedge clk_i);
        cmd_ready_i = 1'b0;
        active_i    = (active_hold > 0);
        while (oi < n && cyc < 600) begin
            rx_valid_i = (ri < n);
            rx_data_i  = (ri < n) ? rx_words[ri] : 32'd0;
            rd_ready_i = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (rd_valid_o && !rd_ready_i) check("stall_rx_ready", 32'(rx_ready_o), 32'd0);
            if (rd_valid_o && rd_ready_i) begin
                check($sformatf("word%0d", oi), rd_data_o, exp_words[oi]);
                check($sformatf("last%0d", oi), 32'(rd_last_o), 32'(oi == n - 1));
                oi++;
            end
            if (rx_valid_i && rx_ready_o) ri++;
            cyc++;
            @(negedge clk_i);
        end
        rx_valid_i = 1'b0;
        rd_ready_i = 1'b1;
        check("stream_count", oi, n);
        for (int i = 0; i < active_hold; i++) begin
            #1;
            check("wait_no_done", 32'({done_o, busy_o}), 32'b01);
            @(negedge clk_i);
        end
        active_i = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (done_o) seen = 1;
            else @(negedge clk_i);
        end
        check("done_seen", 32'(seen), 32'd1);
        @(negedge clk_i);
        #1;
        check("post_done_idle", 32'({busy_o, rd_valid_o, done_o}), 32'd0);
    endtask

    task automatic bad_req(input logic [9:0] b);
        send_req(24'h00_0040, b);
        #1;
        check("bad_err", 32'(err_o), 32'd1);
        check("bad_quiet", 32'({busy_o, tx_valid_o, cmd_valid_o}), 32'd0);
        @(negedge clk_i);
        #1;
        check("bad_err_pulse", 32'(err_o), 32'd0);
        check("bad_quiet2", 32'({busy_o, tx_valid_o, cmd_valid_o}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = 24'd0;
        req_bytes_i = 10'd0;
        abort_i     = 1'b0;
        rd_ready_i  = 1'b1;
        cmd_ready_i = 1'b0;
        tx_ready_i  = 1'b0;
        rx_data_i   = 32'd0;
        rx_valid_i  = 1'b0;
        active_i    = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_ready_be", 32'({req_ready_o, tx_be_o}), 32'h1F);
        check("rst_ctrl", 32'({busy_o, rd_valid_o, rd_last_o, done_o, err_o, cmd_valid_o, cmd_wr_en_o,
                               cmd_rd_en_o, cmd_csaat_o, en_o, sw_rst_o, tx_valid_o, rx_ready_o}), 32'd0);
        check("rst_data", rd_data_o | tx_data_o | {23'd0, cmd_len_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check("en_rise", 32'(en_o), 32'd1);

        // 8-byte read, core stays active 3 cycles after the last word
        rx_words  = '{32'h0302_0100, 32'h0706_0504};
        exp_words = '{32'h0302_0100, 32'h0706_0504};
        send_req(24'h12_3456, 10'd8);
        hdr_phase(24'h12_3456, 9'd7, 0);
        stream(2, 1000, 0, 3);

        // 5 bytes: last word keeps only byte 0
        rx_words  = '{32'hDDCC_BBAA, 32'h4433_2211};
        exp_words = '{32'hDDCC_BBAA, 32'h0000_0011};
        send_req(24'h00_0010, 10'd5);
        hdr_phase(24'h00_0010, 9'd4, 0);
        stream(2, 1000, 0, 0);

        // 16 bytes with consumer stalled for 10 cycles mid-stream
        rx_words  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        exp_words = rx_words;
        send_req(24'hAB_CDEF, 10'd16);
        hdr_phase(24'hAB_CDEF, 9'd15, 0);
        stream(4, 1, 10, 0);

        // Header command held off 5 cycles, TX accepted immediately; 11 bytes -> 3 words, tail 3
        rx_words  = '{32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4};
        exp_words = '{32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'h00C2_C3C4};
        send_req(24'h00_0100, 10'd11);
        hdr_phase(24'h00_0100, 9'd10, 5);
        stream(3, 1000, 0, 0);

        // Largest legal request: 512 bytes, 128 full words
        rx_words.delete();
        for (int i = 0; i < 128; i++) rx_words.push_back(32'hA5A5_0000 ^ 32'(i));
        exp_words = rx_words;
        send_req(24'hFF_FF00, 10'd512);
        hdr_phase(24'hFF_FF00, 9'd511, 0);
        stream(128, 1000, 0, 0);

        // Illegal sizes
        bad_req(10'd0);
        bad_req(10'd513);

        // Abort on the same edge as the read-command handshake
        send_req(24'h00_2000, 10'd8);
        hdr_phase(24'h00_2000, 9'd7, 0);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i     = 1'b0;
        cmd_ready_i = 1'b0;
        #1;
        check("abort_pulse", 32'({sw_rst_o, err_o}), 32'b11);
        check("abort_idle", 32'({busy_o, cmd_valid_o, tx_valid_o, rd_valid_o, rx_ready_o}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #1;
            check("abort_after", 32'({done_o, sw_rst_o, err_o, busy_o}), 32'd0);
        end

        // Reset while the header is pending
        send_req(24'h00_3000, 10'd4);
        #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        #1;
        check("midrst_state", 32'({req_ready_o, busy_o, tx_valid_o, cmd_valid_o, sw_rst_o, en_o}), 32'b100000);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check("midrst_en", 32'(en_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
